// File: rtl/uart_tx_regs.sv
// uart_tx_regs: register-mapped UART transmitter with a TX FIFO.
//
// Register map (register_index):
//   0 DATA    write-only; pushes register_write_value[7:0] into the TX FIFO
//   1 STATUS  read-only; bit0 fifo_full, bit1 busy, bit2 overflow (read clears)
//   2 DIVISOR read/write; bit period = DIVISOR+1 clk cycles
//   others    read 0, writes ignored
//
// Ports:
//   clk                   single clock, rising edge
//   reset                 asynchronous active-low reset
//   register_index[11:0]  register address
//   register_read         read strobe (clears overflow on a STATUS read)
//   register_write        write strobe
//   register_write_value  write data
//   register_read_value   combinational read data selected by register_index
//   tx                    registered serial output, idles high
//
// Optional feature: define UART_TX_PARITY_EN to append one even-parity bit
// between the data bits and the stop bit (11 bit periods per frame instead of 10).
module uart_tx_regs #(
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] register_index,
    input  logic        register_read,
    input  logic        register_write,
    input  logic [15:0] register_write_value,
    output logic [15:0] register_read_value,
    output logic        tx
);

    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    localparam logic [11:0] IDX_DATA    = 12'd0;
    localparam logic [11:0] IDX_STATUS  = 12'd1;
    localparam logic [11:0] IDX_DIVISOR = 12'd2;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    state_t state, state_next;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [7:0]       fifo_head_c;
    logic             fifo_empty_c;
    logic             fifo_full_c;
    logic             push_c;
    logic             pop_c;

    logic             data_wr_c;
    logic             div_wr_c;
    logic             status_rd_c;
    logic             ovf_set_c;
    logic             busy_c;

    logic [15:0]      divisor;
    logic             overflow;

    logic [15:0]      cycle_cnt, cycle_next;
    logic [2:0]       bit_cnt, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic [15:0]      div_lat, div_next;
    logic             tx_next;
    logic             period_done_c;
    logic             load_c;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit, parity_next;
`endif

    // Register decode
    assign data_wr_c   = register_write && (register_index == IDX_DATA);
    assign div_wr_c    = register_write && (register_index == IDX_DIVISOR);
    assign status_rd_c = register_read  && (register_index == IDX_STATUS);

    // FIFO flags: equal index bits with differing wrap bit means full
    assign fifo_empty_c = (wr_ptr == rd_ptr);
    assign fifo_full_c  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                          (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign fifo_head_c  = fifo_mem[rd_ptr[ADDR_W-1:0]];

    // A full FIFO still accepts a write when the transmitter pops in the same cycle
    assign push_c    = data_wr_c && (!fifo_full_c || pop_c);
    assign ovf_set_c = data_wr_c && fifo_full_c && !pop_c;

    assign busy_c        = !fifo_empty_c || (state != ST_IDLE);
    assign period_done_c = (cycle_cnt == div_lat);

    // FIFO pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // FIFO storage, contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_c) fifo_mem[wr_ptr[ADDR_W-1:0]] <= register_write_value[7:0];
    end

    // Divisor register and sticky overflow flag (set beats read-clear)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divisor  <= DEFAULT_DIVISOR;
            overflow <= 1'b0;
        end else begin
            if (div_wr_c) divisor <= register_write_value;
            if (ovf_set_c)        overflow <= 1'b1;
            else if (status_rd_c) overflow <= 1'b0;
        end
    end

    // Transmitter state and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            tx         <= 1'b1;
            cycle_cnt  <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            div_lat    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            tx         <= tx_next;
            cycle_cnt  <= cycle_next;
            bit_cnt    <= bit_next;
            shift_reg  <= shift_next;
            div_lat    <= div_next;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_next;
`endif
        end
    end

    // Next-state and datapath; tx_next is the level driven during the next cycle
    always_comb begin
        state_next  = state;
        tx_next     = tx;
        cycle_next  = cycle_cnt;
        bit_next    = bit_cnt;
        shift_next  = shift_reg;
        div_next    = div_lat;
        load_c      = 1'b0;
        pop_c       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_bit;
`endif

        case (state)
            ST_IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty_c) load_c = 1'b1;
            end

            ST_START: begin
                if (period_done_c) begin
                    state_next = ST_DATA;
                    cycle_next = '0;
                    bit_next   = '0;
                    tx_next    = shift_reg[0];
                end else begin
                    cycle_next = cycle_cnt + 16'd1;
                end
            end

            ST_DATA: begin
                if (period_done_c) begin
                    cycle_next = '0;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = ST_PARITY;
                        tx_next    = parity_bit;
`else
                        state_next = ST_STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        bit_next   = bit_cnt + 3'd1;
                        shift_next = {1'b0, shift_reg[7:1]};
                        tx_next    = shift_reg[1];
                    end
                end else begin
                    cycle_next = cycle_cnt + 16'd1;
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (period_done_c) begin
                    state_next = ST_STOP;
                    cycle_next = '0;
                    tx_next    = 1'b1;
                end else begin
                    cycle_next = cycle_cnt + 16'd1;
                end
            end
`endif

            ST_STOP: begin
                if (period_done_c) begin
                    cycle_next = '0;
                    if (!fifo_empty_c) begin
                        load_c = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                        tx_next    = 1'b1;
                    end
                end else begin
                    cycle_next = cycle_cnt + 16'd1;
                end
            end

            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
            end
        endcase

        // Frame start: pop the head, latch the divisor, drive the start bit
        if (load_c) begin
            pop_c       = 1'b1;
            state_next  = ST_START;
            shift_next  = fifo_head_c;
            div_next    = divisor;
            cycle_next  = '0;
            bit_next    = '0;
            tx_next     = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_next = ^fifo_head_c;
`endif
        end
    end

    // Read mux, independent of register_read
    always_comb begin
        register_read_value = '0;
        case (register_index)
            IDX_STATUS:  register_read_value = {13'd0, overflow, busy_c, fifo_full_c};
            IDX_DIVISOR: register_read_value = divisor;
            default:     register_read_value = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_regs.sv
// Self-checking bench for uart_tx_regs: register-access vector table, directed
// frame sequences and a randomized traffic phase checked by a serial-line monitor
// that derives expected waveforms from queued (byte, divisor) frames.
module tb_uart_tx_regs;

    localparam int unsigned FIFO_DEPTH      = 8;
    localparam logic [15:0] DEFAULT_DIVISOR = 16'd15;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic        clk;
    logic        reset;
    logic [11:0] register_index;
    logic        register_read;
    logic        register_write;
    logic [15:0] register_write_value;
    logic [15:0] register_read_value;
    logic        tx;

    uart_tx_regs #(
        .FIFO_DEPTH      (FIFO_DEPTH),
        .DEFAULT_DIVISOR (DEFAULT_DIVISOR)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .register_index       (register_index),
        .register_read        (register_read),
        .register_write       (register_write),
        .register_write_value (register_write_value),
        .register_read_value  (register_read_value),
        .tx                   (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         div;
    } exp_frame_t;

    typedef struct {
        logic [11:0] idx;
        logic        rd;
        logic        wr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         frames_done   = 0;
    int         frames_pushed = 0;
    bit         mon_en = 1'b1;
    exp_frame_t exp_q[$];
    int         start_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [11:0] idx, input logic [15:0] val);
        register_index       = idx;
        register_write_value = val;
        register_write       = 1'b1;
        tick();
        register_write = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] data, input int div);
        exp_frame_t f;
        f.data = data;
        f.div  = div;
        exp_q.push_back(f);
        frames_pushed++;
    endtask

    task automatic read_chk(input string name, input logic [11:0] idx, input logic [15:0] exp);
        register_index = idx;
        #1;
        chk(name, 32'(register_read_value), 32'(exp));
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(frames_done >= target), 32'd1);
    endtask

    // Serial monitor: each start bit consumes one expected frame and checks every
    // sample of start, LSB-first data, optional even parity and stop bit.
    initial begin : monitor
        exp_frame_t f;
        logic       lvl [12];
        int         nb;
        bit         bad;
        forever begin
            @(negedge clk);
            if (mon_en && reset && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'(tx), 32'd1);
                    for (int w = 0; w < 4000 && tx === 1'b0; w++) @(negedge clk);
                end else begin
                    f = exp_q.pop_front();
                    start_q.push_back(cyc);
                    lvl[0] = 1'b0;
                    for (int i = 0; i < 8; i++) lvl[i+1] = f.data[i];
`ifdef UART_TX_PARITY_EN
                    lvl[9]  = ^f.data;
                    lvl[10] = 1'b1;
`else
                    lvl[9]  = 1'b1;
`endif
                    nb  = FRAME_BITS;
                    bad = 1'b0;
                    for (int b = 0; b < nb && !bad; b++) begin
                        for (int c = 0; c <= f.div && !bad; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (!mon_en || !reset) begin
                                bad = 1'b1;
                            end else begin
                                chk($sformatf("frame_%02h_bit%0d", f.data, b), 32'(tx), 32'(lvl[b]));
                                if (tx !== lvl[b]) bad = 1'b1;
                            end
                        end
                    end
                    frames_done++;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs [12];
        int   div;
        int   k;
        logic [7:0] b;

        reset                = 1'b0;
        register_index       = '0;
        register_read        = 1'b0;
        register_write       = 1'b0;
        register_write_value = '0;

        // Reset state
        repeat (3) tick();
        chk("reset_tx", 32'(tx), 32'd1);
        read_chk("reset_status", 12'd1, 16'h0000);
        read_chk("reset_divisor", 12'd2, DEFAULT_DIVISOR);
        reset = 1'b1;
        tick();

        // Register access table: expected read value is sampled before the edge
        vecs[0]  = '{12'd2,    1'b0, 1'b0, 16'h0000, 16'h000F};
        vecs[1]  = '{12'd1,    1'b1, 1'b0, 16'h0000, 16'h0000};
        vecs[2]  = '{12'd5,    1'b0, 1'b1, 16'hFFFF, 16'h0000};
        vecs[3]  = '{12'd5,    1'b1, 1'b0, 16'h0000, 16'h0000};
        vecs[4]  = '{12'd2,    1'b0, 1'b1, 16'h1234, 16'h000F};
        vecs[5]  = '{12'd2,    1'b0, 1'b0, 16'h0000, 16'h1234};
        vecs[6]  = '{12'd0,    1'b1, 1'b0, 16'h0000, 16'h0000};
        vecs[7]  = '{12'd3,    1'b0, 1'b1, 16'hFFFF, 16'h0000};
        vecs[8]  = '{12'd1,    1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[9]  = '{12'd2,    1'b0, 1'b1, 16'h0003, 16'h1234};
        vecs[10] = '{12'd2,    1'b0, 1'b0, 16'h0000, 16'h0003};
        vecs[11] = '{12'd4095, 1'b1, 1'b1, 16'hFFFF, 16'h0000};
        for (int i = 0; i < 12; i++) begin
            register_index       = vecs[i].idx;
            register_read        = vecs[i].rd;
            register_write       = vecs[i].wr;
            register_write_value = vecs[i].wdata;
            #1;
            chk($sformatf("vec%0d_idx%0d", i, vecs[i].idx), 32'(register_read_value), 32'(vecs[i].exp));
            tick();
            register_read  = 1'b0;
            register_write = 1'b0;
        end
        chk("vec_tx_idle", 32'(tx), 32'd1);
        read_chk("vec_divisor_final", 12'd2, 16'h0003);

        // Single frame at DIVISOR=3, upper data bits ignored, one-cycle latency
        push_exp(8'h41, 3);
        write_reg(12'd0, 16'hFF41);
        chk("latency_edge_n", 32'(tx), 32'd1);
        tick();
        chk("latency_edge_n1", 32'(tx), 32'd0);
        wait_frames(frames_pushed, 100, "frame41_done");
        tick(); tick();
        read_chk("frame41_idle_status", 12'd1, 16'h0000);

        // Ten back-to-back writes at DIVISOR=0: ninth fills, tenth overflows
        write_reg(12'd2, 16'h0000);
        start_q.delete();
        for (int i = 0; i < 10; i++) begin
            if (i < 9) push_exp(8'(i), 0);
            write_reg(12'd0, 16'(i));
        end
        register_index = 12'd1;
        register_read  = 1'b1;
        #1;
        chk("ovf_status_first_read", 32'(register_read_value), 32'h7);
        tick();
        register_read = 1'b0;
        read_chk("ovf_status_second_read", 12'd1, 16'h0003);
        wait_frames(frames_pushed, 9 * FRAME_BITS + 50, "burst_done");
        chk("burst_frame_count", 32'(start_q.size()), 32'd9);
        for (int i = 1; i < start_q.size(); i++)
            chk($sformatf("burst_gap%0d", i), 32'(start_q[i] - start_q[i-1]), 32'(FRAME_BITS));
        repeat (20) tick();
        read_chk("burst_idle_status", 12'd1, 16'h0000);

        // Divisor change mid-frame only affects the following frame
        write_reg(12'd2, 16'd3);
        push_exp(8'hA5, 3);
        write_reg(12'd0, 16'h00A5);
        push_exp(8'h3C, 7);
        write_reg(12'd0, 16'h003C);
        repeat (10) tick();
        write_reg(12'd2, 16'd7);
        wait_frames(frames_pushed, 4 * FRAME_BITS + 8 * FRAME_BITS + 50, "divchg_done");
        tick(); tick();
        read_chk("divchg_status", 12'd1, 16'h0000);
        read_chk("divchg_divisor", 12'd2, 16'd7);

        // Reset during data bit 3 with a second byte still queued
        mon_en = 1'b0;
        write_reg(12'd0, 16'h0000);
        write_reg(12'd0, 16'h0000);
        repeat (35) tick();
        read_chk("midframe_busy", 12'd1, 16'h0002);
        chk("midframe_tx_low", 32'(tx), 32'd0);
        reset = 1'b0;
        #1;
        chk("reset_async_tx", 32'(tx), 32'd1);
        read_chk("reset_async_status", 12'd1, 16'h0000);
        read_chk("reset_async_divisor", 12'd2, DEFAULT_DIVISOR);
        tick(); tick();
        chk("reset_hold_tx", 32'(tx), 32'd1);
        reset  = 1'b1;
        mon_en = 1'b1;
        push_exp(8'h5A, int'(DEFAULT_DIVISOR));
        write_reg(12'd0, 16'h005A);
        chk("post_reset_edge_n", 32'(tx), 32'd1);
        tick();
        chk("post_reset_edge_n1", 32'(tx), 32'd0);
        wait_frames(frames_pushed, 16 * FRAME_BITS + 50, "post_reset_done");
        tick(); tick();
        read_chk("post_reset_status", 12'd1, 16'h0000);

        // Randomized traffic: bursts never exceed FIFO capacity, unmapped accesses in gaps
        for (int it = 0; it < 6; it++) begin
            div = int'($urandom_range(0, 4));
            write_reg(12'd2, 16'(div));
            k = int'($urandom_range(1, FIFO_DEPTH));
            for (int j = 0; j < k; j++) begin
                b = 8'($urandom_range(0, 255));
                push_exp(b, div);
                write_reg(12'd0, {8'($urandom), b});
                for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
                    register_index = 12'd1;
                    #1;
                    chk("rnd_busy", 32'(register_read_value[1]), 32'd1);
                    chk("rnd_no_ovf", 32'(register_read_value[2]), 32'd0);
                    register_index       = 12'($urandom_range(3, 4095));
                    register_write       = 1'($urandom);
                    register_read        = 1'($urandom);
                    register_write_value = 16'($urandom);
                    #1;
                    chk("rnd_unmapped_read", 32'(register_read_value), 32'd0);
                    tick();
                    register_write = 1'b0;
                    register_read  = 1'b0;
                end
            end
            wait_frames(frames_pushed, k * FRAME_BITS * (div + 1) + 100, "rnd_done");
            tick(); tick();
            read_chk("rnd_idle_status", 12'd1, 16'h0000);
            read_chk("rnd_divisor", 12'd2, 16'(div));
        end

        chk("expected_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
